// File: rtl/bus_interface_unit.sv
// bus_interface_unit: sole memory master, sequential instruction prefetch queue plus EU load/store
module bus_interface_unit #(
   parameter int ADDR_WIDTH = 20,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] flush_addr,
   output logic                  q_valid,
   output logic [DATA_WIDTH-1:0] q_data,
   output logic [ADDR_WIDTH-1:0] q_addr,
   input  logic                  q_ready,
   input  logic                  eu_req,
   input  logic                  eu_we,
   input  logic [ADDR_WIDTH-1:0] eu_addr,
   input  logic [DATA_WIDTH-1:0] eu_wdata,
   output logic [DATA_WIDTH-1:0] eu_rdata,
   output logic                  eu_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_in,
   output logic                  mem_write,
   output logic                  mem_enable,
   input  logic [DATA_WIDTH-1:0] mem_out
);
   localparam int PW = $clog2(DEPTH);
   typedef enum logic [2:0] {IDLE, F1, F2, EU_RD1, EU_RD2, EU_WR} state_t;
   state_t state, nxt;
   logic [DATA_WIDTH-1:0] qd [DEPTH];
   logic [ADDR_WIDTH-1:0] qa [DEPTH];
   logic [PW-1:0] head, tail;
   logic [PW:0] count;
   logic [ADDR_WIDTH-1:0] fetch_ptr;
   logic drop, cap, pop;
   assign q_valid = |count;
   assign q_data = qd[head];
   assign q_addr = qa[head];
   assign cap = (state == F2) && !drop && !flush;
   assign pop = q_valid && q_ready && !flush;
   // next state: EU first (ignored while its done pulse is out), then prefetch when room and no flush
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (eu_req && !eu_done) ? (eu_we ? EU_WR : EU_RD1) : (!count[PW] && !flush) ? F1 : IDLE;
         F1:      nxt = F2;
         EU_RD1:  nxt = EU_RD2;
         default: nxt = IDLE;
      endcase
   end
   // state, registered memory strobes, EU results, queue pointers and fetch pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         mem_enable <= 1'b1;
         mem_write <= 1'b1;
         mem_addr <= '0;
         mem_in <= '0;
         eu_done <= 1'b0;
         eu_rdata <= '0;
         count <= '0;
         head <= '0;
         tail <= '0;
         fetch_ptr <= '0;
         drop <= 1'b0;
      end else begin
         state <= nxt;
         mem_enable <= nxt == IDLE;
         mem_write <= nxt != EU_WR;
         mem_addr <= (nxt == F1) ? fetch_ptr : (nxt == EU_RD1 || nxt == EU_WR) ? eu_addr : mem_addr;
         mem_in <= (nxt == EU_WR) ? eu_wdata : mem_in;
         eu_done <= (state == EU_RD2) || (state == EU_WR);
         eu_rdata <= (state == EU_RD2) ? mem_out : eu_rdata;
         drop <= (state == F1) && flush;
         if (flush) begin
            count <= '0;
            head <= '0;
            tail <= '0;
            fetch_ptr <= flush_addr;
         end else begin
            count <= count + {{PW{1'b0}}, cap} - {{PW{1'b0}}, pop};
            head <= pop ? head + PW'(1) : head;
            tail <= cap ? tail + PW'(1) : tail;
            fetch_ptr <= cap ? fetch_ptr + ADDR_WIDTH'(1) : fetch_ptr;
         end
      end
   end
   // queue storage: fetched word and its address land at the tail
   always_ff @(posedge clk) begin
      if (cap) begin
         qd[tail] <= mem_out;
         qa[tail] <= fetch_ptr;
      end
   end
endmodule

// File: doc/bus_interface_unit.md
Name: bus_interface_unit

Overview:
- Sits directly upstream of the 20-bit-address / 16-bit-word memory and is its only master.
- Prefetches sequential instruction words into a small FIFO for the decoder.
- Serves load/store requests from the execution unit (EU); EU requests take priority over prefetch.
- Drives the memory's active-low write and enable strobes.

Parameters:
- ADDR_WIDTH, 20, memory word-address width.
- DATA_WIDTH, 16, memory word width.
- DEPTH, 4, prefetch queue capacity in words (power of 2).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard the queue and restart prefetch at flush_addr.
- flush_addr  in  ADDR_WIDTH  new prefetch word address.
- q_valid  out  1  queue head holds a word.
- q_data  out  DATA_WIDTH  head word.
- q_addr  out  ADDR_WIDTH  word address of the head word.
- q_ready  in  1  decoder pops the head when q_valid && q_ready.
- eu_req  in  1  EU access request; held until eu_done.
- eu_we  in  1  1 = store, 0 = load.
- eu_addr  in  ADDR_WIDTH  EU word address.
- eu_wdata  in  DATA_WIDTH  store data.
- eu_rdata  out  DATA_WIDTH  load result, valid when eu_done.
- eu_done  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_in  out  DATA_WIDTH  memory write data.
- mem_write  out  1  active-low write strobe (0 = write).
- mem_enable  out  1  active-low chip enable (1 = memory output high-Z).
- mem_out  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset values: queue empty, count = 0, fetch_ptr = 0, state IDLE, q_valid = 0, eu_done = 0, eu_rdata = 0, mem_enable = 1, mem_write = 1, mem_addr = 0, mem_in = 0.
- All memory-side outputs are registered.

States and transitions:
- IDLE:
  - if eu_req, go to EU_WR when eu_we = 1, else EU_RD1;
  - else if count < DEPTH and not flush, go to F1;
  - else stay in IDLE.
  - In IDLE, mem_enable = 1 and mem_write = 1.
- F1: mem_addr = fetch_ptr, mem_enable = 0, mem_write = 1. Next state F2.
- F2: address held. At the end of F2, mem_out is captured into the queue tail with address fetch_ptr, and fetch_ptr increments by 1, wrapping modulo 2^ADDR_WIDTH. Next state IDLE.
- EU_RD1: mem_addr = eu_addr, mem_enable = 0. Next state EU_RD2.
- EU_RD2: at the end of EU_RD2, eu_rdata <= mem_out and eu_done <= 1. Next state IDLE.
- EU_WR: mem_addr = eu_addr, mem_in = eu_wdata, mem_write = 0, mem_enable = 0 for exactly one cycle. eu_done <= 1 at the end of EU_WR. Next state IDLE.
- After eu_done, mem_write returns to 1 and mem_enable returns to 1.

Timing:
- Fetch: 2 memory cycles plus 1 IDLE cycle, so 3 cycles per fetch.
- Load: eu_done asserts 3 cycles after eu_req is seen in IDLE.
- Store: eu_done asserts 2 cycles after eu_req is seen in IDLE.
- The EU must deassert eu_req in the cycle after eu_done. eu_req seen again in IDLE starts a new access.

Queue:
- q_valid = (count != 0); q_data and q_addr come from the head entry.
- Pop and capture in the same cycle: both occur and count is unchanged.
- Pop when empty: ignored.
- A fetch is only issued when count < DEPTH. Because only one fetch is ever in flight, capture never overflows.

Flush:
- Takes effect on the edge it is sampled: count <= 0 and fetch_ptr <= flush_addr.
- Flush in F1 or F2: the access finishes its bus cycle, but the captured word is discarded and fetch_ptr is not incremented. The new ptr from the flush is kept.
- Flush on the capture edge: the flush wins.
- Flush during an EU access: the EU access completes normally.
- Flush together with a pop: the flush wins.

Reset mid-access: the state returns to IDLE and the strobes deassert on the next edge. No eu_done is produced for the aborted access.

Test Plan:
- Reset, then memory preloaded with words 0..7 = 0x1000+n, q_ready = 0 -> fetches at addresses 0,1,2,3; queue full with q_data = 0x1000, q_addr = 0; mem_enable stays 1 afterwards and no 5th fetch is issued.
- Full queue, q_ready = 1 for 1 cycle -> q_data becomes 0x1001, q_addr = 1; next fetch issued at addr 4; simultaneous pop and capture keeps count at 4.
- Store eu_addr = 0x0000C, eu_wdata = 0xBEEF during prefetch -> store issued after the current fetch completes; mem_write = 0 for exactly 1 cycle with mem_addr = 0x0000C; eu_done pulses once; a load from 0x0000C then returns eu_rdata = 0xBEEF.
- Flush with flush_addr = 0x00005 asserted during F2 -> queue empty; the captured word is discarded; the next fetch is at addr 5 and the queue head afterwards is 0x1005 with q_addr = 5.
- Flush with flush_addr = 0xFFFFF, then let two fetches complete -> q_addr sequence 0xFFFFF, 0x00000 (wrap).
- rst pulsed during EU_RD2 -> next cycle mem_enable = 1, mem_write = 1, q_valid = 0, and eu_done never asserts.
